// File: rtl/braille_pkg.sv
// Shared definitions for the answer-window timer.
// Holds the seconds-counter width and the window FSM state encoding.
package braille_pkg;

  localparam int unsigned SEC_W = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StExpire = 2'd2
  } win_state_e;

endpackage

// File: rtl/answer_window_timer.sv
// Answer-window timer: counts down a learner's answer window in whole seconds,
// driven by an external 1 s tick, and reports answer / timeout events.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   tick_1s    one-cycle pulse per second from the upstream 1 s timer
//   start      open (or restart) a window; load_sec sampled here
//   load_sec   requested window length in seconds (0 or > MAX_SEC -> MAX_SEC)
//   stop       learner answered
//   timer_clr  one-cycle pulse asking the upstream 1 s timer to restart
//   busy       window running
//   remaining  seconds left in the window
//   elapsed    whole seconds since last accepted start, saturating at 15
//   warn       busy and 0 < remaining <= WARN_SEC
//   timeout    one-cycle pulse: window expired unanswered
//   answered   one-cycle pulse: stop accepted while running
module answer_window_timer
  import braille_pkg::*;
#(
  parameter int unsigned MAX_SEC  = 15,
  parameter int unsigned WARN_SEC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1s,
  input  logic             start,
  input  logic [SEC_W-1:0] load_sec,
  input  logic             stop,
  output logic             timer_clr,
  output logic             busy,
  output logic [SEC_W-1:0] remaining,
  output logic [SEC_W-1:0] elapsed,
  output logic             warn,
  output logic             timeout,
  output logic             answered
);

  localparam logic [SEC_W-1:0] MaxSec  = SEC_W'(MAX_SEC);
  localparam logic [SEC_W-1:0] WarnSec = SEC_W'(WARN_SEC);
  localparam logic [SEC_W-1:0] SecSat  = '1;

  win_state_e       state_q, state_d;
  logic [SEC_W-1:0] remaining_q, remaining_d;
  logic [SEC_W-1:0] elapsed_q, elapsed_d;
  logic             busy_q, busy_d;
  logic             warn_q, warn_d;
  logic             timeout_q, timeout_d;
  logic             answered_q, answered_d;
  logic             timer_clr_q, timer_clr_d;
  logic [SEC_W-1:0] eff_len;

  always_comb begin
    eff_len = load_sec;
    if (load_sec == '0 || load_sec > MaxSec) begin
      eff_len = MaxSec;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    elapsed_d   = elapsed_q;
    timeout_d   = 1'b0;
    answered_d  = 1'b0;
    timer_clr_d = 1'b0;

    // start wins over everything in every state, discarding same-cycle stop/tick.
    if (start) begin
      state_d     = StRun;
      remaining_d = eff_len;
      elapsed_d   = '0;
      timer_clr_d = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (stop) begin
            // Answer freezes the counters; a same-cycle tick is dropped.
            state_d    = StIdle;
            answered_d = 1'b1;
          end else if (tick_1s) begin
            if (elapsed_q != SecSat) begin
              elapsed_d = elapsed_q + 1'b1;
            end
            // <= 1 guards against a zero count ever stalling in RUN.
            if (remaining_q <= SEC_W'(1)) begin
              remaining_d = '0;
              state_d     = StExpire;
              timeout_d   = 1'b1;
            end else begin
              remaining_d = remaining_q - 1'b1;
            end
          end
        end
        StExpire: state_d = StIdle;
        StIdle:   state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end

    busy_d = (state_d == StRun);
    warn_d = busy_d && (remaining_d != '0) && (remaining_d <= WarnSec);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      elapsed_q   <= '0;
      busy_q      <= 1'b0;
      warn_q      <= 1'b0;
      timeout_q   <= 1'b0;
      answered_q  <= 1'b0;
      timer_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      elapsed_q   <= elapsed_d;
      busy_q      <= busy_d;
      warn_q      <= warn_d;
      timeout_q   <= timeout_d;
      answered_q  <= answered_d;
      timer_clr_q <= timer_clr_d;
    end
  end

  assign timer_clr = timer_clr_q;
  assign busy      = busy_q;
  assign remaining = remaining_q;
  assign elapsed   = elapsed_q;
  assign warn      = warn_q;
  assign timeout   = timeout_q;
  assign answered  = answered_q;

endmodule

// File: tb/tb_answer_window_timer.sv
// Self-checking bench for answer_window_timer (MAX_SEC=6, WARN_SEC=3).
// Each scenario lists per-cycle stimulus and hand-derived expected outputs;
// expectations are queued as stimulus is driven and popped after the edge.
module tb_answer_window_timer;

  typedef struct packed {
    logic       rst;
    logic       start;
    logic [3:0] load;
    logic       stop;
    logic       tick;
  } stim_t;

  typedef struct packed {
    logic       busy;
    logic [3:0] rem;
    logic [3:0] el;
    logic       warn;
    logic       to;
    logic       ans;
    logic       clr;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1s = 1'b0;
  logic       start = 1'b0;
  logic [3:0] load_sec = '0;
  logic       stop = 1'b0;
  logic       timer_clr, busy, warn, timeout, answered;
  logic [3:0] remaining, elapsed;

  int   total = 0;
  int   bad = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  answer_window_timer #(
    .MAX_SEC (6),
    .WARN_SEC(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1s  (tick_1s),
    .start    (start),
    .load_sec (load_sec),
    .stop     (stop),
    .timer_clr(timer_clr),
    .busy     (busy),
    .remaining(remaining),
    .elapsed  (elapsed),
    .warn     (warn),
    .timeout  (timeout),
    .answered (answered)
  );

  function automatic stim_t s(input logic r, input logic st, input logic [3:0] ld,
                              input logic sp, input logic tk);
    s = '{rst: r, start: st, load: ld, stop: sp, tick: tk};
  endfunction

  function automatic obs_t o(input logic b, input logic [3:0] rm, input logic [3:0] e,
                             input logic w, input logic t, input logic a, input logic c);
    o = '{busy: b, rem: rm, el: e, warn: w, to: t, ans: a, clr: c};
  endfunction

  function automatic obs_t sample();
    sample = '{busy: busy, rem: remaining, el: elapsed, warn: warn, to: timeout,
               ans: answered, clr: timer_clr};
  endfunction

  // Queue the expectation, apply one cycle of stimulus, sample #1 after the edge.
  task automatic drive(input stim_t st, input obs_t e);
    exp_q.push_back(e);
    rst      = st.rst;
    start    = st.start;
    load_sec = st.load;
    stop     = st.stop;
    tick_1s  = st.tick;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; load_sec = '0; stop = 1'b0; tick_1s = 1'b0;
  endtask

  task automatic test_reset();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  got, e;
    st = {s(1,0,0,0,0), s(1,0,0,1,1), s(1,0,0,0,0),
          s(0,0,0,0,1), s(0,0,0,0,0), s(0,0,0,1,1), s(0,0,0,0,0), s(0,0,0,0,1)};
    for (int i = 0; i < st.size(); i++) ex.push_back(o(0,0,0,0,0,0,0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i], ex[i]);
      got = sample(); e = exp_q.pop_front(); total++;
      if (got !== e) begin
        bad++; $display("FAIL reset[%0d]: got %b want %b", i, got, e);
      end
    end
  endtask

  task automatic test_countdown();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  got, e;
    st = {s(0,1,4,0,0), s(0,0,0,0,0), s(0,0,0,0,1), s(0,0,0,0,1), s(0,0,0,0,0),
          s(0,0,0,0,1), s(0,0,0,0,1), s(0,0,0,1,1), s(0,0,0,0,1), s(0,0,0,1,0)};
    ex = {o(1,4,0,0,0,0,1), o(1,4,0,0,0,0,0), o(1,3,1,1,0,0,0), o(1,2,2,1,0,0,0),
          o(1,2,2,1,0,0,0), o(1,1,3,1,0,0,0), o(0,0,4,0,1,0,0), o(0,0,4,0,0,0,0),
          o(0,0,4,0,0,0,0), o(0,0,4,0,0,0,0)};
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i], ex[i]);
      got = sample(); e = exp_q.pop_front(); total++;
      if (got !== e) begin
        bad++; $display("FAIL countdown[%0d]: got %b want %b", i, got, e);
      end
    end
  endtask

  task automatic test_answer();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  got, e;
    st = {s(0,1,5,0,0), s(0,0,0,0,1), s(0,0,0,0,1), s(0,0,0,1,0),
          s(0,0,0,0,1), s(0,0,0,1,1), s(0,0,0,0,1)};
    ex = {o(1,5,0,0,0,0,1), o(1,4,1,0,0,0,0), o(1,3,2,1,0,0,0), o(0,3,2,0,0,1,0),
          o(0,3,2,0,0,0,0), o(0,3,2,0,0,0,0), o(0,3,2,0,0,0,0)};
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i], ex[i]);
      got = sample(); e = exp_q.pop_front(); total++;
      if (got !== e) begin
        bad++; $display("FAIL answer[%0d]: got %b want %b", i, got, e);
      end
    end
  endtask

  task automatic test_clamp();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  got, e;
    st = {s(0,1,0,0,0), s(0,0,0,0,1), s(0,1,9,0,0), s(0,1,15,0,1), s(0,1,6,0,0),
          s(0,1,2,0,0), s(0,0,0,1,0)};
    ex = {o(1,6,0,0,0,0,1), o(1,5,1,0,0,0,0), o(1,6,0,0,0,0,1), o(1,6,0,0,0,0,1),
          o(1,6,0,0,0,0,1), o(1,2,0,1,0,0,1), o(0,2,0,0,0,1,0)};
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i], ex[i]);
      got = sample(); e = exp_q.pop_front(); total++;
      if (got !== e) begin
        bad++; $display("FAIL clamp[%0d]: got %b want %b", i, got, e);
      end
    end
  endtask

  task automatic test_race();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  got, e;
    st = {s(0,1,2,0,0), s(0,0,0,0,1), s(0,0,0,1,1), s(0,0,0,0,1),
          s(0,1,3,0,0), s(0,0,0,0,1), s(0,1,5,1,1), s(0,0,0,0,1), s(0,0,0,1,0)};
    ex = {o(1,2,0,1,0,0,1), o(1,1,1,1,0,0,0), o(0,1,1,0,0,1,0), o(0,1,1,0,0,0,0),
          o(1,3,0,1,0,0,1), o(1,2,1,1,0,0,0), o(1,5,0,0,0,0,1), o(1,4,1,0,0,0,0),
          o(0,4,1,0,0,1,0)};
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i], ex[i]);
      got = sample(); e = exp_q.pop_front(); total++;
      if (got !== e) begin
        bad++; $display("FAIL race[%0d]: got %b want %b", i, got, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  got, e;
    // Restart on the EXPIRE cycle goes straight back to RUN.
    st = {s(0,1,1,0,0), s(0,0,0,0,1), s(0,1,3,0,0), s(0,0,0,0,1), s(0,0,0,1,0)};
    ex = {o(1,1,0,1,0,0,1), o(0,0,1,0,1,0,0), o(1,3,0,1,0,0,1), o(1,2,1,1,0,0,0),
          o(0,2,1,0,0,1,0)};
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i], ex[i]);
      got = sample(); e = exp_q.pop_front(); total++;
      if (got !== e) begin
        bad++; $display("FAIL back_to_back[%0d]: got %b want %b", i, got, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  got, e;
    st = {s(0,1,4,0,0), s(0,0,0,0,1), s(0,0,0,0,1), s(1,0,0,0,1), s(0,0,0,0,1),
          s(0,0,0,0,1), s(0,0,0,0,1), s(0,1,4,0,0), s(1,1,4,1,1), s(0,0,0,0,1)};
    ex = {o(1,4,0,0,0,0,1), o(1,3,1,1,0,0,0), o(1,2,2,1,0,0,0), o(0,0,0,0,0,0,0),
          o(0,0,0,0,0,0,0), o(0,0,0,0,0,0,0), o(0,0,0,0,0,0,0), o(1,4,0,0,0,0,1),
          o(0,0,0,0,0,0,0), o(0,0,0,0,0,0,0)};
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i], ex[i]);
      got = sample(); e = exp_q.pop_front(); total++;
      if (got !== e) begin
        bad++; $display("FAIL reset_mid[%0d]: got %b want %b", i, got, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_answer();
    test_clamp();
    test_race();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
